din_debounce: RTL and testbench



---
 rtl/din_debounce_pkg.sv | 10 +
 rtl/din_debounce_sync_chain.sv | 14 +
 rtl/din_debounce.sv | 86 ++++++++
 tb/tb_din_debounce.sv | 139 +++++++++++++
 4 files changed

// File: rtl/din_debounce_pkg.sv
// din_debounce_pkg: debouncer state encoding and glitch counter width
package din_debounce_pkg;
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_e;
  localparam int GLITCH_W = 8;
endpackage

// File: rtl/din_debounce_sync_chain.sv
// sync_chain: SYNC_STAGES-deep flop synchroniser with synchronous reset
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
  always_ff @(posedge clk) sync_q <= reset ? '0 : sync_d;
  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/din_debounce.sv
// din_debounce: synchronise and debounce din_raw; glitch_cnt port with DIN_DEBOUNCE_GLITCH_CNT_EN
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout,
  output logic settling
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s, glitch, last;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, settling_q, settling_d;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(din_raw),
    .q(s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    glitch = 1'b0;
    last = cnt_q == CNT_LAST;
    case (state_q)
      LOW: begin
        state_d = s ? RISE_CHK : LOW;
        cnt_d = s ? CNT_W'(1) : '0;
      end
      RISE_CHK: begin
        glitch = !s;
        state_d = !s ? LOW : last ? HIGH : RISE_CHK;
        cnt_d = (!s || last) ? '0 : cnt_q + 1'b1;
      end
      HIGH: begin
        state_d = s ? HIGH : FALL_CHK;
        cnt_d = s ? '0 : CNT_W'(1);
      end
      FALL_CHK: begin
        glitch = s;
        state_d = s ? HIGH : last ? LOW : FALL_CHK;
        cnt_d = (s || last) ? '0 : cnt_q + 1'b1;
      end
      default: begin
        state_d = LOW;
        cnt_d = '0;
      end
    endcase
    dout_d = state_d inside {HIGH, FALL_CHK};
    settling_d = state_d inside {RISE_CHK, FALL_CHK};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q <= '0;
      dout_q <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      settling_q <= settling_d;
    end
  end
  assign dout = dout_q;
  assign settling = settling_q;
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
  always_comb glitch_cnt_d = (glitch && glitch_cnt_q != '1) ? glitch_cnt_q + 1'b1 : glitch_cnt_q;
  always_ff @(posedge clk) glitch_cnt_q <= reset ? '0 : glitch_cnt_d;
  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch;
`endif
endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce: random and directed stimulus against a run-length debounce model
module tb_din_debounce;
  localparam int SYNC_STAGES = 2;
  localparam int STABLE_CYCLES = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din_raw = 1'b0;
  logic dout, settling;
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [SYNC_STAGES-1:0] m_sync = '0;
  int m_run = 0;
  logic m_dout = 1'b0;
  int m_glitch = 0;
  int dout_seen = 0;
  always #5 clk = ~clk;
  din_debounce #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk(clk),
    .reset(reset),
    .din_raw(din_raw),
    .dout(dout),
    .settling(settling)
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  // model: dout flips once STABLE_CYCLES consecutive delayed samples disagree with it
  function automatic void model(input logic d, input logic r);
    logic s;
    if (r) begin
      m_sync = '0;
      m_run = 0;
      m_dout = 1'b0;
      m_glitch = 0;
    end else begin
      s = m_sync[SYNC_STAGES-1];
      m_sync = {m_sync[SYNC_STAGES-2:0], d};
      if (s != m_dout) begin
        m_run++;
        if (m_run == STABLE_CYCLES) begin
          m_dout = s;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
  endfunction
  task automatic cmp_model();
    chk("model_dout", dout, m_dout);
    chk("model_settling", settling, m_run != 0);
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    chk("model_glitch_cnt", glitch_cnt, m_glitch);
`endif
    if (dout) dout_seen++;
  endtask
  task automatic step(input logic d, input logic r);
    din_raw = d;
    reset = r;
    @(posedge clk);
    model(d, r);
    #1;
    cmp_model();
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("rst_dout", dout, 0);
      chk("rst_settling", settling, 0);
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
      chk("rst_glitch_cnt", glitch_cnt, 0);
`endif
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      chk("rise_settling", settling, i >= 3 && i <= 5);
      chk("rise_dout", dout, i >= 6);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      chk("fall_settling", settling, i >= 3 && i <= 5);
      chk("fall_dout", dout, i < 6);
    end
    for (int i = 1; i <= 10; i++) begin
      step(i <= 2, 1'b0);
      chk("glitch_settling", settling, i == 3 || i == 4);
      chk("glitch_dout", dout, 0);
    end
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_count_one", glitch_cnt, 1);
`endif
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("high_before_reset", dout, 1);
    step(1'b1, 1'b1);
    chk("reset_high_dout", dout, 0);
    chk("reset_high_settling", settling, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      chk("post_reset_dout", dout, i >= 6);
    end
    for (int b = 0; b < 300; b++) begin
      logic v, r;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      r = $urandom_range(0, 99) == 0;
      for (int j = 0; j < len; j++) step(v, r && j == 0);
    end
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    dout_seen = 0;
    for (int g = 0; g < 300; g++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("sat_glitch_cnt", glitch_cnt, 255);
    chk("sat_dout_never_high", dout_seen, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
